// File: rtl/mic1_bus_pkg.sv
// Shared constants and types for the MIC-1 memory bridge.
// It defines the FSM state codes, the operation kinds and the beat-count helpers.
package mic1_bus_pkg;

  localparam int unsigned BEATS_WORD = 4;
  localparam int unsigned BEATS_BYTE = 1;
  localparam int unsigned STATE_W    = 3;

  typedef logic [STATE_W-1:0] state_t;

  localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
  localparam logic [STATE_W-1:0] S_ADDR = 3'd1;
  localparam logic [STATE_W-1:0] S_WAIT = 3'd2;
  localparam logic [STATE_W-1:0] S_DATA = 3'd3;
  localparam logic [STATE_W-1:0] S_DONE = 3'd4;

  typedef enum logic [1:0] {
    OP_RD    = 2'd0,
    OP_WR    = 2'd1,
    OP_FETCH = 2'd2
  } op_kind_t;

  // Index of the final data beat for an operation kind.
  function automatic logic [1:0] last_data_beat(input op_kind_t kind);
    return (kind == OP_FETCH) ? 2'(BEATS_BYTE - 1) : 2'(BEATS_WORD - 1);
  endfunction

endpackage

// File: rtl/mic1_mem_bridge.sv
// Serialises MIC-1 word read/write and opcode-fetch requests onto an 8-bit pad bus.
// The assembled MDR word or MBR byte is returned with a one-cycle valid pulse.
module mic1_mem_bridge #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] mar_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [31:0]       mdr_in,
  output logic [31:0]       mdr_out,
  output logic              mdr_valid,
  output logic [7:0]        mbr_out,
  output logic              mbr_valid,
  output logic              wr_done,
  output logic              busy,
  output logic              proto_err,
  output logic [7:0]        pad_out,
  input  logic [7:0]        pad_in,
  output logic              pad_oe,
  output logic [1:0]        bus_sel,
  output logic              bus_ale,
  output logic              bus_we,
  output logic              bus_re
);
  import mic1_bus_pkg::*;

  localparam int unsigned LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

  state_t            state, state_nxt;
  op_kind_t          op, op_nxt;
  logic [1:0]        beat, beat_nxt;
  logic [LAT_W-1:0]  lat, lat_nxt;
  logic              fetch_pend, pend_nxt;
  logic [ADDR_W-1:0] cur_addr, addr_nxt;
  logic [ADDR_W-1:0] pc_hold, pc_nxt;
  logic [31:0]       wdata, wdata_nxt;

  logic [31:0] mdr_nxt;
  logic [7:0]  mbr_nxt;
  logic [7:0]  pad_nxt;
  logic [1:0]  sel_nxt;
  logic        mdr_valid_nxt, mbr_valid_nxt, wr_done_nxt, busy_nxt, proto_nxt;
  logic        oe_nxt, ale_nxt, we_nxt, re_nxt;

  // MAR[31:30] fall off the word-to-byte shift.
  logic [1:0] unused_mar_hi;
  assign unused_mar_hi = mar_in[ADDR_W-1:ADDR_W-2];

  // Next state, counters and next values of every registered output.
  always_comb begin
    state_nxt = state;
    op_nxt    = op;
    beat_nxt  = beat;
    lat_nxt   = lat;
    pend_nxt  = fetch_pend;
    addr_nxt  = cur_addr;
    pc_nxt    = pc_hold;
    wdata_nxt = wdata;
    mdr_nxt   = mdr_out;
    mbr_nxt   = mbr_out;
    proto_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (rd_req || wr_req || fetch_req) begin
          state_nxt = S_ADDR;
          beat_nxt  = 2'd0;
          pc_nxt    = pc_in;
          wdata_nxt = mdr_in;
          pend_nxt  = fetch_req && (rd_req || wr_req);
          proto_nxt = rd_req && wr_req;
          if (wr_req) begin
            op_nxt   = OP_WR;
            addr_nxt = {mar_in[ADDR_W-3:0], 2'b00};
          end else if (rd_req) begin
            op_nxt   = OP_RD;
            addr_nxt = {mar_in[ADDR_W-3:0], 2'b00};
          end else begin
            op_nxt   = OP_FETCH;
            addr_nxt = pc_in;
          end
        end
      end
      S_ADDR: begin
        if (beat == 2'(BEATS_WORD - 1)) begin
          beat_nxt = 2'd0;
          lat_nxt  = '0;
          state_nxt = (op == OP_WR || RD_LATENCY == 0) ? S_DATA : S_WAIT;
        end else begin
          beat_nxt = beat + 2'd1;
        end
      end
      S_WAIT: begin
        if (lat == LAT_LAST) begin
          state_nxt = S_DATA;
        end else begin
          lat_nxt = lat + LAT_W'(1);
        end
      end
      S_DATA: begin
        if (op == OP_RD) begin
          mdr_nxt[{beat, 3'b000} +: 8] = pad_in;
        end
        if (op == OP_FETCH) begin
          mbr_nxt = pad_in;
        end
        if (beat == last_data_beat(op)) begin
          beat_nxt  = 2'd0;
          state_nxt = S_DONE;
        end else begin
          beat_nxt = beat + 2'd1;
        end
      end
      S_DONE: begin
        if (fetch_pend) begin
          state_nxt = S_ADDR;
          op_nxt    = OP_FETCH;
          addr_nxt  = pc_hold;
          pend_nxt  = 1'b0;
          beat_nxt  = 2'd0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        pend_nxt  = 1'b0;
      end
    endcase

    // Bus strobes for the cycle the FSM is about to enter.
    ale_nxt = (state_nxt == S_ADDR);
    we_nxt  = (state_nxt == S_DATA) && (op_nxt == OP_WR);
    re_nxt  = (state_nxt == S_DATA) && (op_nxt != OP_WR);
    oe_nxt  = ale_nxt || we_nxt;
    sel_nxt = (ale_nxt || state_nxt == S_DATA) ? beat_nxt : 2'd0;
    if (ale_nxt) begin
      pad_nxt = addr_nxt[{beat_nxt, 3'b000} +: 8];
    end else if (we_nxt) begin
      pad_nxt = wdata_nxt[{beat_nxt, 3'b000} +: 8];
    end else begin
      pad_nxt = 8'h00;
    end

    mdr_valid_nxt = (state_nxt == S_DONE) && (op_nxt == OP_RD);
    wr_done_nxt   = (state_nxt == S_DONE) && (op_nxt == OP_WR);
    mbr_valid_nxt = (state_nxt == S_DONE) && (op_nxt == OP_FETCH);
    busy_nxt      = (state_nxt != S_IDLE) || pend_nxt;
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op         <= OP_RD;
      beat       <= 2'd0;
      lat        <= '0;
      fetch_pend <= 1'b0;
      cur_addr   <= '0;
      pc_hold    <= '0;
      wdata      <= '0;
      mdr_out    <= '0;
      mbr_out    <= '0;
      mdr_valid  <= 1'b0;
      mbr_valid  <= 1'b0;
      wr_done    <= 1'b0;
      busy       <= 1'b0;
      proto_err  <= 1'b0;
      pad_out    <= '0;
      pad_oe     <= 1'b0;
      bus_sel    <= 2'd0;
      bus_ale    <= 1'b0;
      bus_we     <= 1'b0;
      bus_re     <= 1'b0;
    end else begin
      state      <= state_nxt;
      op         <= op_nxt;
      beat       <= beat_nxt;
      lat        <= lat_nxt;
      fetch_pend <= pend_nxt;
      cur_addr   <= addr_nxt;
      pc_hold    <= pc_nxt;
      wdata      <= wdata_nxt;
      mdr_out    <= mdr_nxt;
      mbr_out    <= mbr_nxt;
      mdr_valid  <= mdr_valid_nxt;
      mbr_valid  <= mbr_valid_nxt;
      wr_done    <= wr_done_nxt;
      busy       <= busy_nxt;
      proto_err  <= proto_nxt;
      pad_out    <= pad_nxt;
      pad_oe     <= oe_nxt;
      bus_sel    <= sel_nxt;
      bus_ale    <= ale_nxt;
      bus_we     <= we_nxt;
      bus_re     <= re_nxt;
    end
  end

endmodule

// File: tb/tb_mic1_mem_bridge.sv
// Bench for mic1_mem_bridge: two instances (RD_LATENCY 1 and 0) share stimulus and are
// compared every cycle against a per-cycle timeline built from the transaction timing rules.
module tb_mic1_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rd_req, wr_req, fetch_req;
  logic [31:0] mar_in, pc_in, mdr_in;
  logic [7:0]  pad_in;

  logic [1:0][31:0] mdr_out;
  logic [1:0][7:0]  mbr_out, pad_out;
  logic [1:0][1:0]  bus_sel;
  logic [1:0]       mdr_valid, mbr_valid, wr_done, busy, proto_err, pad_oe, bus_ale, bus_we, bus_re;

  mic1_mem_bridge #(.RD_LATENCY(1), .ADDR_W(32)) u_l1 (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .fetch_req(fetch_req),
    .mar_in(mar_in), .pc_in(pc_in), .mdr_in(mdr_in),
    .mdr_out(mdr_out[0]), .mdr_valid(mdr_valid[0]), .mbr_out(mbr_out[0]), .mbr_valid(mbr_valid[0]),
    .wr_done(wr_done[0]), .busy(busy[0]), .proto_err(proto_err[0]),
    .pad_out(pad_out[0]), .pad_in(pad_in), .pad_oe(pad_oe[0]), .bus_sel(bus_sel[0]),
    .bus_ale(bus_ale[0]), .bus_we(bus_we[0]), .bus_re(bus_re[0])
  );

  mic1_mem_bridge #(.RD_LATENCY(0), .ADDR_W(32)) u_l0 (
    .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req), .fetch_req(fetch_req),
    .mar_in(mar_in), .pc_in(pc_in), .mdr_in(mdr_in),
    .mdr_out(mdr_out[1]), .mdr_valid(mdr_valid[1]), .mbr_out(mbr_out[1]), .mbr_valid(mbr_valid[1]),
    .wr_done(wr_done[1]), .busy(busy[1]), .proto_err(proto_err[1]),
    .pad_out(pad_out[1]), .pad_in(pad_in), .pad_oe(pad_oe[1]), .bus_sel(bus_sel[1]),
    .bus_ale(bus_ale[1]), .bus_we(bus_we[1]), .bus_re(bus_re[1])
  );

  // Expected bus activity for one instance in one cycle.
  typedef struct packed {
    logic       ale, we, re, oe;
    logic [1:0] sel;
    logic [7:0] pad;
    logic       mv, bv, wd, pe, busy;
    logic       rdb_en;
    logic [1:0] rdb;
    logic       fb;
  } ent_t;

  ent_t        tbl [2][4096];
  logic [31:0] e_mdr [2];
  logic [7:0]  e_mbr [2];
  int          last_done [2];
  int          k;
  int          n_assert = 0;
  int          n_fail = 0;

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic logic [58:0] act_vec(input int i);
    return {mdr_out[i], mbr_out[i], pad_out[i], bus_sel[i], mdr_valid[i], mbr_valid[i],
            wr_done[i], busy[i], proto_err[i], pad_oe[i], bus_ale[i], bus_we[i], bus_re[i]};
  endfunction

  function automatic logic [58:0] exp_vec(input int i);
    ent_t e;
    e = tbl[i][k];
    return {e_mdr[i], e_mbr[i], e.pad, e.sel, e.mv, e.bv, e.wd, e.busy, e.pe,
            e.oe, e.ale, e.we, e.re};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_cycle();
    for (int i = 0; i < 2; i++)
      chk($sformatf("outputs L=%0d cycle %0d", lat_of(i), k), 64'(act_vec(i)), 64'(exp_vec(i)));
  endtask

  // Word op: 4 address beats, optional read wait, 4 data beats, one done cycle.
  task automatic fill_word(input int i, input int s, input bit is_wr, input logic [31:0] ba,
                           input logic [31:0] wd, output int done);
    int l;
    int e;
    l = lat_of(i);
    for (int n = 0; n < 4; n++) begin
      tbl[i][s+n].ale = 1'b1;
      tbl[i][s+n].oe  = 1'b1;
      tbl[i][s+n].sel = 2'(n);
      tbl[i][s+n].pad = ba[8*n +: 8];
    end
    if (is_wr) begin
      for (int n = 0; n < 4; n++) begin
        e = s + 4 + n;
        tbl[i][e].we  = 1'b1;
        tbl[i][e].oe  = 1'b1;
        tbl[i][e].sel = 2'(n);
        tbl[i][e].pad = wd[8*n +: 8];
      end
      done = s + 8;
      tbl[i][done].wd = 1'b1;
    end else begin
      for (int n = 0; n < 4; n++) begin
        e = s + 4 + l + n;
        tbl[i][e].re     = 1'b1;
        tbl[i][e].sel    = 2'(n);
        tbl[i][e].rdb_en = 1'b1;
        tbl[i][e].rdb    = 2'(n);
      end
      done = s + 8 + l;
      tbl[i][done].mv = 1'b1;
    end
    for (int c = s; c <= done; c++) tbl[i][c].busy = 1'b1;
  endtask

  // Fetch: 4 address beats of the PC, read wait, a single lane-0 data beat, one done cycle.
  task automatic fill_fetch(input int i, input int s, input logic [31:0] pc, output int done);
    int e;
    for (int n = 0; n < 4; n++) begin
      tbl[i][s+n].ale = 1'b1;
      tbl[i][s+n].oe  = 1'b1;
      tbl[i][s+n].sel = 2'(n);
      tbl[i][s+n].pad = pc[8*n +: 8];
    end
    e = s + 4 + lat_of(i);
    tbl[i][e].re  = 1'b1;
    tbl[i][e].fb  = 1'b1;
    done = e + 1;
    tbl[i][done].bv = 1'b1;
    for (int c = s; c <= done; c++) tbl[i][c].busy = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the reference model, then check the next cycle.
  task automatic step(input bit r, input bit rd, input bit wr, input bit fe,
                      input logic [31:0] mar, input logic [31:0] pc,
                      input logic [31:0] wdat, input logic [7:0] pin);
    int d;
    int b;
    rst = r; rd_req = rd; wr_req = wr; fetch_req = fe;
    mar_in = mar; pc_in = pc; mdr_in = wdat; pad_in = pin;
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        e_mdr[i] = '0;
        e_mbr[i] = '0;
        for (int j = k + 1; j <= k + 40; j++) tbl[i][j] = '0;
        last_done[i] = k;
      end else begin
        if (tbl[i][k].rdb_en) begin
          b = int'(tbl[i][k].rdb);
          e_mdr[i][8*b +: 8] = pin;
        end
        if (tbl[i][k].fb) e_mbr[i] = pin;
        if (k > last_done[i] && (rd || wr || fe)) begin
          d = k;
          if (rd || wr) fill_word(i, k + 1, wr, {mar[29:0], 2'b00}, wdat, d);
          if (rd && wr) tbl[i][k+1].pe = 1'b1;
          if (fe) fill_fetch(i, (rd || wr) ? d + 1 : k + 1, pc, d);
          last_done[i] = d;
        end
      end
    end
    @(negedge clk);
    k++;
    check_cycle();
  endtask

  task automatic idle(input logic [7:0] pin);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, pin);
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((k <= last_done[0] || k <= last_done[1]) && g < 100) begin
      idle(8'h00);
      g++;
    end
    if (g >= 100) begin
      n_assert++;
      n_fail++;
      $error("FAIL wait_idle: still busy at cycle %0d after %0d cycles", k, g);
    end
  endtask

  initial begin
    int t;
    logic [7:0] rb [4];
    rb[0] = 8'h78; rb[1] = 8'h56; rb[2] = 8'h34; rb[3] = 8'h12;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4096; j++) tbl[i][j] = '0;
      e_mdr[i] = '0;
      e_mbr[i] = '0;
      last_done[i] = -1;
    end
    rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; fetch_req = 1'b0;
    mar_in = '0; pc_in = '0; mdr_in = '0; pad_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    k = 0;
    check_cycle();

    // Idle after reset.
    repeat (5) idle(8'h00);
    chk("idle busy", 64'(busy), 64'(2'b00));
    chk("idle mdr_out", 64'(mdr_out[0]), 64'h0);

    // Word read of MAR 0x10, bytes 78 56 34 12 on the L=1 data beats.
    t = k;
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 8'h00);
    for (int c = 1; c <= 9; c++) idle((c >= 6) ? rb[c-6] : 8'h00);
    chk("read mdr_out at T+10", 64'(mdr_out[0]), 64'h12345678);
    chk("read mdr_valid at T+10", 64'(mdr_valid[0]), 64'h1);
    chk("read elapsed", 64'(k - t), 64'd10);
    wait_idle();

    // Write of 0xCAFEBABE to MAR 0x3.
    t = k;
    step(1'b0, 1'b0, 1'b1, 1'b0, 32'h3, 32'h0, 32'hCAFEBABE, 8'h00);
    repeat (8) idle(8'h00);
    chk("wr_done at T+9", 64'(wr_done), 64'(2'b11));
    chk("pad_oe off at T+9", 64'(pad_oe), 64'(2'b00));
    wait_idle();

    // Read plus fetch of PC 0x100; the fetch follows the read's done cycle.
    t = k;
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h20, 32'h100, 32'h0, 8'hA5);
    repeat (16) idle(8'hA5);
    chk("fetch mbr_out at T+17", 64'(mbr_out[0]), 64'hA5);
    chk("fetch mbr_valid at T+17", 64'(mbr_valid[0]), 64'h1);
    wait_idle();

    // Read and write together, then a read while busy.
    t = k;
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 32'h01234567, 8'h00);
    chk("proto_err at T+1", 64'(proto_err), 64'(2'b11));
    idle(8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h99, 32'h0, 32'h0, 8'h11);
    wait_idle();

    // Reset during read data beat 2, then a fresh read.
    t = k;
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 32'h0, 8'h00);
    repeat (7) idle(8'($urandom));
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 8'h66);
    chk("busy after reset", 64'(busy), 64'(2'b00));
    chk("mdr_out after reset", 64'(mdr_out[0]), 64'h0);
    t = k;
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h7, 32'h0, 32'h0, 8'h3C);
    repeat (8) idle(8'h3C);
    chk("L0 mdr_valid at T+9", 64'(mdr_valid[1]), 64'h1);
    chk("L0 mdr_out at T+9", 64'(mdr_out[1]), 64'h3C3C3C3C);
    wait_idle();

    // Random traffic, including occasional resets.
    repeat (1500) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0, $urandom, $urandom, $urandom, 8'($urandom));
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mic1_mem_bridge.md
Name: mic1_mem_bridge

Overview:
- Memory-side neighbour of the MIC-1 datapath.
- Accepts the datapath's word read/write (MAR/MDR) and opcode-fetch (PC/MBR) requests, then serialises each 32-bit address and data word over an 8-bit pad bus, one byte per cycle.
- Returns the assembled MDR word or MBR byte with a one-cycle valid pulse.
- Replaces ad-hoc byte muxing of MAR onto the output pins.

Parameters:
- RD_LATENCY, 1: wait cycles between the last address beat and the first data beat (0 legal; WAIT state skipped).
- ADDR_W, 32: width of mar_in / pc_in (fixed 32; informational).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rd_req  in  1  word read from MAR
- wr_req  in  1  word write of MDR to MAR
- fetch_req  in  1  byte read from PC
- mar_in  in  32  word address; byte address = {mar_in[29:0],2'b00}
- pc_in  in  32  byte address for fetch
- mdr_in  in  32  write data
- mdr_out  out  32  read data
- mdr_valid  out  1  pulse: word read complete
- mbr_out  out  8  fetched byte
- mbr_valid  out  1  pulse: fetch complete
- wr_done  out  1  pulse: write complete
- busy  out  1  high whenever not IDLE or a fetch is pending
- proto_err  out  1  pulse: rd_req and wr_req accepted together
- pad_out  out  8  address/write-data byte
- pad_in  in  8  read-data byte
- pad_oe  out  1  pad_out drive enable
- bus_sel  out  2  byte lane index of current beat (0 = LSB)
- bus_ale  out  1  address beat strobe
- bus_we  out  1  write data beat strobe
- bus_re  out  1  read data beat strobe (pad_in sampled this cycle)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, and overrides everything. Reset mid-transfer aborts the transfer, drops any pending fetch, and returns to IDLE.
- Reset values: all outputs 0, including mdr_out and mbr_out.
- Acceptance: a request is accepted only in IDLE with busy=0. Requests presented while busy are ignored, not queued.
- Latching: on acceptance, mar_in, pc_in and mdr_in are captured into internal registers.
- Conflicts on the acceptance cycle:
  - rd_req and wr_req both high: the write proceeds, the read is dropped, and proto_err pulses in the following cycle.
  - A word op together with fetch_req: the word op runs first; the fetch is marked pending and starts in the cycle after the word op's DONE.
- States:
  - IDLE.
  - ADDR: 4 beats; bus_ale=1, pad_oe=1, pad_out = address byte bus_sel, bus_sel 0..3.
  - WAIT: RD_LATENCY cycles; all strobes 0. Entered for reads and fetches only; writes go ADDR→DATA directly.
  - DATA:
    - Read: 4 beats, bus_re=1, byte n of pad_in sampled into mdr_out[8n+7:8n].
    - Write: 4 beats, bus_we=1, pad_oe=1, pad_out = mdr byte n.
    - Fetch: 1 beat, bus_sel=0, bus_re=1, sample into mbr_out.
  - DONE: 1 cycle; the matching valid/done pulse is asserted, then the FSM goes to ADDR for a pending fetch, otherwise IDLE.
- Timing (acceptance in cycle T, L = RD_LATENCY; each pulse lasts exactly 1 cycle):
  - Word read: ADDR T+1..T+4, WAIT T+5..T+4+L, DATA T+5+L..T+8+L, mdr_valid at T+9+L.
  - Write: ADDR T+1..T+4, DATA T+5..T+8, wr_done at T+9.
  - Fetch: ADDR T+1..T+4, DATA T+5+L, mbr_valid at T+6+L.
- Output holding:
  - mdr_out changes only during read DATA beats and otherwise holds.
  - mbr_out updates only on the fetch beat.
  - A partially assembled mdr_out is visible during DATA; the word is valid only with mdr_valid.
- Outside active states: pad_out=0, pad_oe=0.
- Address handling: unsigned; no wrap checks. MAR bits [31:30] are discarded by the shift.

Decomposition:
- Package mic1_bus_pkg:
  - FSM state enum (IDLE, ADDR, WAIT, DATA, DONE)
  - op-kind enum (OP_RD, OP_WR, OP_FETCH)
  - BEATS_WORD=4, BEATS_BYTE=1
- No sub-module required. Beat counter, latency counter and byte shift/assemble logic stay inline.

Test Plan:
- Reset, then idle 5 cycles → all outputs 0, busy=0.
- Word read, L=1, mar_in=0x00000010, pad_in beats 0x78,0x56,0x34,0x12 → pad_out 0x40,0x00,0x00,0x00 with bus_ale; mdr_out=0x12345678; mdr_valid exactly at T+10.
- Write, mar_in=0x3, mdr_in=0xCAFEBABE → pad_out 0x0C,0,0,0 then 0xBE,0xBA,0xFE,0xCA with bus_we, pad_oe=1 for 8 cycles; wr_done at T+9.
- rd_req+fetch_req same cycle, pc_in=0x100, fetch data 0xA5 → mdr_valid first; fetch ADDR begins the cycle after DONE; mbr_out=0xA5 with mbr_valid; busy stays high throughout.
- rd_req+wr_req together → write executes, proto_err pulses once at T+1, no mdr_valid. Also: rd_req raised while busy → ignored.
- rst asserted during read DATA beat 2 → next cycle IDLE, outputs 0, no valid pulse; a fresh read with RD_LATENCY=0 completes at T+9.
